// File: rtl/pkt_words_to_bytes_if.sv
// Word-side and byte-side handshake bundle for the packet word-to-byte serializer.
// The slave modport is the serializer, the master modport is its surroundings.
interface pkt_words_to_bytes_if;
    logic [31:0] in_data;
    logic [11:0] in_bytecount;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  txdata;
    logic        txvalid;
    logic        txready;
    logic        txeop;

    modport master (
        output in_data, in_bytecount, in_last, in_valid,
        input  in_ready,
        input  txdata, txvalid, txeop,
        output txready
    );

    modport slave (
        input  in_data, in_bytecount, in_last, in_valid,
        output in_ready,
        output txdata, txvalid, txeop,
        input  txready
    );
endinterface

// File: rtl/pkt_words_to_bytes.sv
// Serializes little-endian 32-bit packet words into a byte stream, with optional
// zero padding to a minimum length, optional IEEE 802.3 FCS, and an end-of-packet strobe.
module pkt_words_to_bytes #(
    parameter int unsigned WITH_CRC_APPEND = 1,
    parameter int unsigned MIN_LEN         = 60
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pkt_words_to_bytes_if.slave   bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_PAD  = 3'd2;
    localparam logic [2:0] S_CRC  = 3'd3;
    localparam logic [2:0] S_EOP  = 3'd4;

    localparam logic [2:0]  S_TAIL    = (WITH_CRC_APPEND != 0) ? S_CRC : S_EOP;
    localparam logic        PAD_EN    = (MIN_LEN != 0);
    localparam logic [11:0] PAD_LIMIT = (MIN_LEN == 0) ? 12'd1 : 12'(MIN_LEN);
    localparam logic [31:0] CRC_POLY  = 32'hEDB88320;

    logic [2:0]  state;
    logic [31:0] word;
    logic [1:0]  idx;
    logic [1:0]  last_idx;
    logic        word_last;
    logic        waiting;
    logic [11:0] len;
    logic [31:0] crc;
    logic [1:0]  fcs_idx;

    logic [7:0]  data_byte;
    logic [7:0]  fcs_byte;
    logic [31:0] fcs;
    logic        data_beat;
    logic        data_fire;
    logic        word_end;
    logic        accept;
    logic [11:0] len_inc;
    logic        pad_needed;
    logic        unused_bc;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Only the low two count bits matter: they size the final word.
    assign unused_bc = ^bus.in_bytecount[11:2];

    assign fcs = ~crc;

    always_comb begin
        data_byte = word[7:0];
        case (idx)
            2'd0: data_byte = word[7:0];
            2'd1: data_byte = word[15:8];
            2'd2: data_byte = word[23:16];
            2'd3: data_byte = word[31:24];
            default: data_byte = word[7:0];
        endcase
    end

    always_comb begin
        fcs_byte = fcs[7:0];
        case (fcs_idx)
            2'd0: fcs_byte = fcs[7:0];
            2'd1: fcs_byte = fcs[15:8];
            2'd2: fcs_byte = fcs[23:16];
            2'd3: fcs_byte = fcs[31:24];
            default: fcs_byte = fcs[7:0];
        endcase
    end

    assign data_beat  = (state == S_DATA) && !waiting;
    assign data_fire  = data_beat && bus.txready;
    assign word_end   = data_fire && (idx == last_idx);
    assign len_inc    = len + 12'd1;
    assign pad_needed = PAD_EN && (len_inc < PAD_LIMIT);

    // The next word may only be taken once the final byte of the current one goes out.
    always_comb begin
        bus.in_ready = 1'b0;
        if (rst_n) begin
            if (state == S_IDLE) begin
                bus.in_ready = 1'b1;
            end else if (state == S_DATA) begin
                bus.in_ready = waiting || (word_end && !word_last);
            end
        end
    end

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        bus.txdata  = '0;
        bus.txvalid = 1'b0;
        case (state)
            S_DATA: begin
                if (!waiting) begin
                    bus.txvalid = 1'b1;
                    bus.txdata  = data_byte;
                end
            end
            S_PAD: begin
                bus.txvalid = 1'b1;
            end
            S_CRC: begin
                bus.txvalid = 1'b1;
                bus.txdata  = fcs_byte;
            end
            default: begin
                bus.txvalid = 1'b0;
            end
        endcase
    end

    assign bus.txeop = (state == S_EOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            word      <= '0;
            idx       <= '0;
            last_idx  <= '0;
            word_last <= 1'b0;
            waiting   <= 1'b0;
            len       <= '0;
            crc       <= '1;
            fcs_idx   <= '0;
        end else begin
            // Word loads are shared by IDLE, the DATA wait slot and the zero-bubble reload.
            if (accept) begin
                word      <= bus.in_data;
                last_idx  <= bus.in_last ? (bus.in_bytecount[1:0] - 2'd1) : 2'd3;
                word_last <= bus.in_last;
                idx       <= '0;
                waiting   <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (data_fire) begin
                        crc <= crc_next(crc, data_byte);
                        len <= len_inc;
                        if (word_end) begin
                            if (word_last) begin
                                state <= pad_needed ? S_PAD : S_TAIL;
                            end else if (!accept) begin
                                waiting <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                S_PAD: begin
                    if (bus.txready) begin
                        crc <= crc_next(crc, 8'h00);
                        len <= len_inc;
                        if (!pad_needed) begin
                            state <= S_TAIL;
                        end
                    end
                end
                S_CRC: begin
                    if (bus.txready) begin
                        fcs_idx <= fcs_idx + 2'd1;
                        if (fcs_idx == 2'd3) begin
                            state <= S_EOP;
                        end
                    end
                end
                S_EOP: begin
                    crc     <= '1;
                    len     <= '0;
                    fcs_idx <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_words_to_bytes.sv
// Directed bench for pkt_words_to_bytes: three instances cover no-FCS, FCS-only and
// FCS with 60-byte padding; each has its own word driver and byte recorder.
module tb_pkt_words_to_bytes;
    logic clk;
    logic rst_n;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;

    logic [31:0] sd [3][64];
    logic [11:0] sb [3][64];
    logic        sl [3][64];
    int unsigned nw [3];
    logic        flush [3];
    logic        rnd_rdy [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned nbytes(input logic [11:0] bc, input logic l);
        if (!l || bc[1:0] == 2'd0) return 4;
        return int'(bc[1:0]);
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else r = r >> 1;
        end
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        pkt_words_to_bytes_if bus ();
        pkt_words_to_bytes #(
            .WITH_CRC_APPEND((g == 0) ? 0 : 1),
            .MIN_LEN((g == 2) ? 60 : 0)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus)
        );

        logic [7:0]  rx [512];
        int unsigned rx_t [512];
        int unsigned eop_t [32];
        int unsigned rx_cnt, eop_cnt, wp, pend, hold_err, ready_err, overlap_err;
        logic        cur_last, stall;
        logic [7:0]  stall_data;

        initial begin
            rx_cnt = 0; eop_cnt = 0; wp = 0; pend = 0;
            hold_err = 0; ready_err = 0; overlap_err = 0;
            cur_last = 1'b0; stall = 1'b0; stall_data = '0;
            bus.in_valid = 1'b0; bus.in_data = '0; bus.in_bytecount = '0;
            bus.in_last = 1'b0; bus.txready = 1'b1;
            forever begin
                @(negedge clk);
                if (flush[g]) wp = nw[g];
                if (wp < nw[g]) begin
                    bus.in_valid     = 1'b1;
                    bus.in_data      = sd[g][wp];
                    bus.in_bytecount = sb[g][wp];
                    bus.in_last      = sl[g][wp];
                end else begin
                    bus.in_valid = 1'b0;
                end
                bus.txready = rnd_rdy[g] ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                // Values seen here are the ones the next rising edge will act on.
                if (!rst_n) begin
                    pend = 0; stall = 1'b0; cur_last = 1'b0;
                end else begin
                    if (stall && (!bus.txvalid || bus.txdata !== stall_data)) hold_err++;
                    stall      = bus.txvalid && !bus.txready;
                    stall_data = bus.txdata;
                    if (bus.txvalid && bus.txeop) overlap_err++;
                    if (bus.in_ready && (bus.txeop || (pend > 0 &&
                        (cur_last || pend > 1 || !(bus.txvalid && bus.txready))))) ready_err++;
                    if (bus.txvalid && bus.txready) begin
                        rx[rx_cnt % 512]   = bus.txdata;
                        rx_t[rx_cnt % 512] = cyc;
                        rx_cnt++;
                        if (pend > 0) pend--;
                    end
                    if (bus.txeop) begin
                        eop_t[eop_cnt % 32] = cyc;
                        eop_cnt++;
                    end
                    if (bus.in_valid && bus.in_ready) begin
                        pend    += nbytes(sb[g][wp], sl[g][wp]);
                        cur_last = sl[g][wp];
                        wp++;
                    end
                end
            end
        end
    end

    task automatic add_word(input int d, input logic [31:0] data, input logic [11:0] bc,
                            input logic l);
        sd[d][nw[d]] = data;
        sb[d][nw[d]] = bc;
        sl[d][nw[d]] = l;
        nw[d]++;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #2;
        n_checks++;
        if (u[0].bus.txvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_txvalid: got %b want 0", u[0].bus.txvalid);
        end
        n_checks++;
        if (u[0].bus.txeop !== 1'b0) begin
            n_fail++; $display("FAIL reset_txeop: got %b want 0", u[0].bus.txeop);
        end
        n_checks++;
        if (u[2].bus.txdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_txdata: got %h want 00", u[2].bus.txdata);
        end
        n_checks++;
        if (u[1].bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 0", u[1].bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        n_checks++;
        if (u[1].bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_in_ready: got %b want 1", u[1].bus.in_ready);
        end
    endtask

    task automatic test_basic;
        logic [7:0] exp [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int unsigned b0 = u[0].rx_cnt;
        int unsigned e0 = u[0].eop_cnt;
        add_word(0, 32'h44332211, 12'd4, 1'b0);
        add_word(0, 32'h00006655, 12'd6, 1'b1);
        for (int c = 0; c < 100 && u[0].eop_cnt < e0 + 1; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (u[0].eop_cnt !== e0 + 1) begin
            n_fail++; $display("FAIL basic_eop_count: got %0d want %0d", u[0].eop_cnt, e0 + 1);
        end
        n_checks++;
        if (u[0].rx_cnt - b0 !== 6) begin
            n_fail++; $display("FAIL basic_byte_count: got %0d want 6", u[0].rx_cnt - b0);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (u[0].rx[b0 + i] !== exp[i]) begin
                n_fail++; $display("FAIL basic_byte%0d: got %h want %h", i, u[0].rx[b0 + i], exp[i]);
            end
        end
        n_checks++;
        if (u[0].rx_t[b0 + 5] - u[0].rx_t[b0] !== 5) begin
            n_fail++; $display("FAIL basic_consecutive: span %0d want 5", u[0].rx_t[b0 + 5] - u[0].rx_t[b0]);
        end
        n_checks++;
        if (u[0].eop_t[e0] - u[0].rx_t[b0 + 5] !== 1) begin
            n_fail++; $display("FAIL basic_eop_timing: gap %0d want 1", u[0].eop_t[e0] - u[0].rx_t[b0 + 5]);
        end
        n_checks++;
        if (u[0].bus.txvalid !== 1'b0 || u[0].bus.txeop !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle: got txvalid=%b txeop=%b want 0 0", u[0].bus.txvalid, u[0].bus.txeop);
        end
    endtask

    task automatic send_check_123456789(input string tag);
        logic [7:0] exp [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                                 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        int unsigned b0 = u[1].rx_cnt;
        int unsigned e0 = u[1].eop_cnt;
        add_word(1, 32'h34333231, 12'd4, 1'b0);
        add_word(1, 32'h38373635, 12'd8, 1'b0);
        add_word(1, 32'h00000039, 12'd9, 1'b1);
        for (int c = 0; c < 100 && u[1].eop_cnt < e0 + 1; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if (u[1].eop_cnt !== e0 + 1) begin
            n_fail++; $display("FAIL %s_eop_count: got %0d want %0d", tag, u[1].eop_cnt, e0 + 1);
        end
        n_checks++;
        if (u[1].rx_cnt - b0 !== 13) begin
            n_fail++; $display("FAIL %s_byte_count: got %0d want 13", tag, u[1].rx_cnt - b0);
        end
        for (int i = 0; i < 13; i++) begin
            n_checks++;
            if (u[1].rx[(b0 + i) % 512] !== exp[i]) begin
                n_fail++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, u[1].rx[(b0 + i) % 512], exp[i]);
            end
        end
    endtask

    task automatic test_crc;
        send_check_123456789("crc");
    endtask

    task automatic check_frame2(input string tag, input int unsigned b0, input int unsigned e0);
        logic [31:0] r = 32'hFFFFFFFF;
        n_checks++;
        if (u[2].eop_cnt !== e0 + 1) begin
            n_fail++; $display("FAIL %s_eop_count: got %0d want %0d", tag, u[2].eop_cnt, e0 + 1);
        end
        n_checks++;
        if (u[2].rx_cnt - b0 !== 64) begin
            n_fail++; $display("FAIL %s_byte_count: got %0d want 64", tag, u[2].rx_cnt - b0);
        end
        for (int i = 0; i < 64; i++) r = crc_byte(r, u[2].rx[(b0 + i) % 512]);
        n_checks++;
        if (r !== 32'hDEBB20E3) begin
            n_fail++; $display("FAIL %s_residue: got %h want DEBB20E3", tag, r);
        end
    endtask

    task automatic test_pad;
        int unsigned b0 = u[2].rx_cnt;
        int unsigned e0 = u[2].eop_cnt;
        add_word(2, 32'h000000AB, 12'd1, 1'b1);
        for (int c = 0; c < 200 && u[2].eop_cnt < e0 + 1; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_frame2("pad", b0, e0);
        n_checks++;
        if (u[2].rx[b0 % 512] !== 8'hAB) begin
            n_fail++; $display("FAIL pad_first: got %h want AB", u[2].rx[b0 % 512]);
        end
        for (int i = 1; i < 60; i++) begin
            n_checks++;
            if (u[2].rx[(b0 + i) % 512] !== 8'h00) begin
                n_fail++; $display("FAIL pad_zero%0d: got %h want 00", i, u[2].rx[(b0 + i) % 512]);
            end
        end
    endtask

    task automatic test_min_len_boundary;
        int unsigned b0 = u[2].rx_cnt;
        int unsigned e0 = u[2].eop_cnt;
        for (int k = 0; k < 15; k++) begin
            add_word(2, {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)},
                     12'(4 * (k + 1)), k == 14);
        end
        for (int c = 0; c < 200 && u[2].eop_cnt < e0 + 1; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_frame2("len60", b0, e0);
        for (int i = 0; i < 60; i++) begin
            n_checks++;
            if (u[2].rx[(b0 + i) % 512] !== 8'(i)) begin
                n_fail++; $display("FAIL len60_byte%0d: got %h want %h", i, u[2].rx[(b0 + i) % 512], 8'(i));
            end
        end
    endtask

    task automatic test_backpressure;
        int unsigned b0 = u[0].rx_cnt;
        int unsigned e0 = u[0].eop_cnt;
        rnd_rdy[0] = 1'b1;
        add_word(0, 32'h03020100, 12'd4, 1'b0);
        add_word(0, 32'h07060504, 12'd8, 1'b0);
        add_word(0, 32'h00000908, 12'd10, 1'b1);
        for (int c = 0; c < 400 && u[0].eop_cnt < e0 + 1; c++) @(negedge clk);
        rnd_rdy[0] = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (u[0].eop_cnt !== e0 + 1) begin
            n_fail++; $display("FAIL bp_eop_count: got %0d want %0d", u[0].eop_cnt, e0 + 1);
        end
        n_checks++;
        if (u[0].rx_cnt - b0 !== 10) begin
            n_fail++; $display("FAIL bp_byte_count: got %0d want 10", u[0].rx_cnt - b0);
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (u[0].rx[(b0 + i) % 512] !== 8'(i)) begin
                n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, u[0].rx[(b0 + i) % 512], 8'(i));
            end
        end
        n_checks++;
        if (u[0].hold_err !== 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d violations want 0", u[0].hold_err);
        end
        n_checks++;
        if (u[0].ready_err !== 0) begin
            n_fail++; $display("FAIL bp_in_ready_early: got %0d violations want 0", u[0].ready_err);
        end
    endtask

    task automatic test_reset_mid;
        int unsigned b0 = u[1].rx_cnt;
        int unsigned e0 = u[1].eop_cnt;
        add_word(1, 32'h44434241, 12'd4, 1'b0);
        add_word(1, 32'h48474645, 12'd8, 1'b0);
        add_word(1, 32'h00000049, 12'd9, 1'b1);
        for (int c = 0; c < 100 && u[1].rx_cnt < b0 + 2; c++) @(negedge clk);
        n_checks++;
        if (u[1].rx_cnt < b0 + 2) begin
            n_fail++; $display("FAIL rstmid_start: got %0d bytes want >=2", u[1].rx_cnt - b0);
        end
        #2;
        flush[1] = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (u[1].bus.txvalid !== 1'b0 || u[1].bus.txeop !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_immediate: got txvalid=%b txeop=%b want 0 0", u[1].bus.txvalid, u[1].bus.txeop);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            n_checks++;
            if (u[1].bus.txvalid !== 1'b0 || u[1].bus.txeop !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_hold%0d: got txvalid=%b txeop=%b want 0 0", k, u[1].bus.txvalid, u[1].bus.txeop);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        flush[1] = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (u[1].eop_cnt !== e0) begin
            n_fail++; $display("FAIL rstmid_no_eop: got %0d eops want %0d", u[1].eop_cnt, e0);
        end
        send_check_123456789("rstmid");
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
        int unsigned b0 = u[0].rx_cnt;
        int unsigned e0 = u[0].eop_cnt;
        add_word(0, 32'hDDCCBBAA, 12'd4, 1'b1);
        add_word(0, 32'h44332211, 12'd4, 1'b1);
        for (int c = 0; c < 100 && u[0].eop_cnt < e0 + 2; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if (u[0].eop_cnt !== e0 + 2) begin
            n_fail++; $display("FAIL b2b_eop_count: got %0d want %0d", u[0].eop_cnt, e0 + 2);
        end
        n_checks++;
        if (u[0].rx_cnt - b0 !== 8) begin
            n_fail++; $display("FAIL b2b_byte_count: got %0d want 8", u[0].rx_cnt - b0);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (u[0].rx[(b0 + i) % 512] !== exp[i]) begin
                n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, u[0].rx[(b0 + i) % 512], exp[i]);
            end
        end
        n_checks++;
        if (u[0].eop_t[e0 % 32] - u[0].rx_t[(b0 + 3) % 512] !== 1) begin
            n_fail++; $display("FAIL b2b_eop1_timing: gap %0d want 1", u[0].eop_t[e0 % 32] - u[0].rx_t[(b0 + 3) % 512]);
        end
        n_checks++;
        if (u[0].rx_t[(b0 + 4) % 512] - u[0].eop_t[e0 % 32] !== 2) begin
            n_fail++; $display("FAIL b2b_restart_gap: gap %0d want 2", u[0].rx_t[(b0 + 4) % 512] - u[0].eop_t[e0 % 32]);
        end
        n_checks++;
        if (u[0].ready_err !== 0) begin
            n_fail++; $display("FAIL b2b_in_ready_early: got %0d violations want 0", u[0].ready_err);
        end
    endtask

    task automatic test_global_rules;
        for (int d = 0; d < 3; d++) begin
            int unsigned ov = (d == 0) ? u[0].overlap_err : (d == 1) ? u[1].overlap_err : u[2].overlap_err;
            int unsigned he = (d == 0) ? u[0].hold_err : (d == 1) ? u[1].hold_err : u[2].hold_err;
            n_checks++;
            if (ov !== 0) begin
                n_fail++; $display("FAIL eop_overlap_dut%0d: got %0d want 0", d, ov);
            end
            n_checks++;
            if (he !== 0) begin
                n_fail++; $display("FAIL hold_dut%0d: got %0d want 0", d, he);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cyc = 0;
        n_checks = 0;
        n_fail = 0;
        for (int d = 0; d < 3; d++) begin
            nw[d] = 0;
            flush[d] = 1'b0;
            rnd_rdy[d] = 1'b0;
        end
        test_reset();
        test_basic();
        test_crc();
        test_pad();
        test_min_len_boundary();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_global_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
